mul_sched: RTL and testbench
============================

MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter PIPE_STAGES, default 1, product register stages after the operand register (1..4).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of 2, >= PIPE_STAGES+1).
REQ-005 SHALL have ports, in order:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept.
- req_a  in  NUM_REQ*WIDTH  multiplicand, requester i at slice i.
- req_b  in  NUM_REQ*WIDTH  multiplier, requester i at slice i.
- mul_a  out  WIDTH  operand to the shared combinational Dadda multiplier.
- mul_b  out  WIDTH  second operand to the multiplier.
- mul_p  in  2*WIDTH  unsigned product from the multiplier.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  clog2(NUM_REQ)  originating requester index.
- rsp_prod  out  2*WIDTH  product.

Function
REQ-006 SHALL grant exactly one valid requester per cycle by round-robin; priority starts at the index after the last accepted requester; after reset, index 0 has top priority.
REQ-007 SHALL assert req_ready[i] only when i is granted and occupancy (in-flight entries + FIFO count) < FIFO_DEPTH; a same-cycle FIFO pop does not free a credit.
REQ-008 SHALL accept on an edge where req_valid[i] && req_ready[i]; the operand register captures {i, a, b}; the RR pointer advances only on acceptance.
REQ-009 SHALL drive mul_a/mul_b from the operand register; mul_p SHALL be captured into product stage 1 on the edge after acceptance, then shift one stage per edge.
REQ-010 SHALL write the last stage into the FIFO; result is visible on rsp_valid after edge k+PIPE_STAGES+1 for an acceptance at edge k into an empty FIFO.
REQ-011 SHALL sustain one acceptance per cycle with no bubbles while credits remain and rsp_ready is high.
REQ-012 SHALL pop the FIFO on rsp_valid && rsp_ready; rsp_id/rsp_prod SHALL hold stable while rsp_valid && !rsp_ready.
REQ-013 SHALL support simultaneous FIFO push and pop at any occupancy, including full; pointers wrap modulo FIFO_DEPTH.
REQ-014 SHALL deliver results in acceptance order; the FIFO SHALL never overflow (credit-guaranteed).
REQ-015 SHALL keep mul_a/mul_b at their last values when idle; req_ready SHALL be combinational from req_valid, pointer and occupancy.

Reset
REQ-016 SHALL, on rst_n low, asynchronously clear: all stage valids, FIFO pointers/count, RR pointer (0), operand/product data (0); rsp_valid=0, req_ready=0, rsp_id=0, rsp_prod=0, mul_a=mul_b=0.
REQ-017 SHALL discard in-flight and buffered results on reset mid-operation; none SHALL appear after release.

Configuration
REQ-018 SHALL, with MUL_SCHED_STATS_EN defined, add outputs stat_sel (in, clog2(NUM_REQ)) and stat_cnt (out, 16): per-requester accepted-request counters, saturating at 0xFFFF, reset to 0, stat_cnt = counter[stat_sel] combinationally.
REQ-019 SHALL, without MUL_SCHED_STATS_EN, omit these ports and counters; all other behaviour is identical.

Structure
REQ-020 SHALL place default WIDTH/NUM_REQ/PIPE_STAGES/FIFO_DEPTH constants and the stage entry struct (valid, id, product) typedef in package mul_sched_pkg.
REQ-021 SHALL implement arbitration in one sub-module rr_arbiter (request vector, advance strobe -> one-hot grant, index).

Verification
REQ-022 Reset idle: rst_n=0 then 1, no requests -> rsp_valid=0, req_ready=0 for 20 cycles.
REQ-023 Single request: req 2, a=0xFF, b=0xFF, accepted edge k -> rsp_valid after edge k+2 (PIPE_STAGES=1), rsp_id=2, rsp_prod=0xFE01.
REQ-024 Fairness: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,... and one result per cycle.
REQ-025 Backpressure: rsp_ready=0, requester 0 streaming -> exactly FIFO_DEPTH (4) accepts, then req_ready=0; rsp_ready=1 -> results in order, no loss or duplication.
REQ-026 Reset mid-flight: assert rst_n=0 with 3 results pending -> after release, rsp_valid=0 until a new acceptance; with MUL_SCHED_STATS_EN all stat_cnt=0.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared constants and the product-stage entry type for the multiply scheduler.
// Entry fields are sized for the largest legal configuration and trimmed at use.
package mul_sched_pkg;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_NUM_REQ     = 4;
    localparam int unsigned DEF_PIPE_STAGES = 1;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;

    localparam int unsigned MAX_WIDTH  = 32;
    localparam int unsigned MAX_ID_W   = 3;
    localparam int unsigned MAX_PROD_W = 2 * MAX_WIDTH;
    localparam int unsigned STAT_W     = 16;

    typedef struct packed {
        logic                  valid;
        logic [MAX_ID_W-1:0]   id;
        logic [MAX_PROD_W-1:0] prod;
    } stage_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mul_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index among active requests.
// Priority pointer moves to the slot after the granted one only when adv is high.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  gnt_c,
    output logic [IW-1:0] idx_c
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] pos;
    logic          found;

    // Scan from the pointer, wrapping modulo N, and take the first request.
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            pos = IW'((32'(ptr_q) + off) % N);
            if (!found && req[pos]) begin
                found      = 1'b1;
                gnt_c[pos] = 1'b1;
                idx_c      = pos;
            end
        end
        ptr_d = ptr_q;
        if (adv) begin
            ptr_d = (idx_c == IW'(N - 1)) ? '0 : idx_c + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mul_sched.sv
// Credit-based scheduler sharing one external multiplier among NUM_REQ requesters.
// Define MUL_SCHED_STATS_EN to add per-requester accept counters (stat_sel/stat_cnt).
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter int unsigned PIPE_STAGES = DEF_PIPE_STAGES,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [2*WIDTH-1:0]         mul_p,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [2*WIDTH-1:0]         rsp_prod
`ifdef MUL_SCHED_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    output logic [STAT_W-1:0]          stat_cnt
`endif
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + PIPE_STAGES + 2);

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [OCC_W-1:0]   occ;
    logic               credit;
    logic               accept;

    logic               op_v_q,  op_v_d;
    logic [ID_W-1:0]    op_id_q, op_id_d;
    logic [WIDTH-1:0]   op_a_q,  op_a_d;
    logic [WIDTH-1:0]   op_b_q,  op_b_d;

    stage_t             stage_q [PIPE_STAGES];
    stage_t             stage_d [PIPE_STAGES];

    stage_t             mem_q [FIFO_DEPTH];
    stage_t             mem_d [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, wr_d;
    logic [AW-1:0]      rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push;
    logic               pop;
    stage_t             head;
    logic               unused_head;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .adv   (accept),
        .gnt_c (gnt),
        .idx_c (gnt_idx)
    );

    // Every entry between acceptance and FIFO pop holds a credit.
    always_comb begin
        occ = OCC_W'(cnt_q) + OCC_W'(op_v_q);
        for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
            occ = occ + OCC_W'(stage_q[s].valid);
        end
    end

    assign credit    = rst_n && (occ < OCC_W'(FIFO_DEPTH));
    assign req_ready = gnt & {NUM_REQ{credit}};
    assign accept    = |(req_valid & req_ready);

    // Operand register keeps its last operands when nothing is accepted.
    always_comb begin
        op_v_d  = accept;
        op_id_d = op_id_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        if (accept) begin
            op_id_d = gnt_idx;
            op_a_d  = req_a[32'(gnt_idx) * WIDTH +: WIDTH];
            op_b_d  = req_b[32'(gnt_idx) * WIDTH +: WIDTH];
        end
    end

    assign mul_a = op_a_q;
    assign mul_b = op_b_q;

    always_comb begin
        stage_d          = stage_q;
        stage_d[0].valid = op_v_q;
        stage_d[0].id    = MAX_ID_W'(op_id_q);
        stage_d[0].prod  = MAX_PROD_W'(mul_p);
        for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    assign push      = stage_q[PIPE_STAGES-1].valid;
    assign rsp_valid = (cnt_q != '0);
    assign pop       = rsp_valid && rsp_ready;

    // Result FIFO; credits guarantee a push never lands on a full FIFO without a pop.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = stage_q[PIPE_STAGES-1];
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign head        = mem_q[rd_q];
    assign rsp_id      = head.id[ID_W-1:0];
    assign rsp_prod    = head.prod[2*WIDTH-1:0];
    assign unused_head = ^{head.valid, head.id, head.prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_v_q  <= 1'b0;
            op_id_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            stage_q <= '{default: '0};
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            op_v_q  <= op_v_d;
            op_id_q <= op_id_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            stage_q <= stage_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MUL_SCHED_STATS_EN
    logic [STAT_W-1:0] scnt_q [NUM_REQ];
    logic [STAT_W-1:0] scnt_d [NUM_REQ];

    always_comb begin
        scnt_d = scnt_q;
        if (accept) begin
            scnt_d[gnt_idx] = sat_inc(scnt_q[gnt_idx]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q <= '{default: '0};
        end else begin
            scnt_q <= scnt_d;
        end
    end

    always_comb begin
        stat_cnt = '0;
        if (32'(stat_sel) < NUM_REQ) begin
            stat_cnt = scnt_q[stat_sel];
        end
    end
`endif

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched with a behavioural multiplier and an in-order result scoreboard.
// Honours MUL_SCHED_STATS_EN for the optional counter ports.
module tb_mul_sched;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;
    localparam int unsigned P = 1;
    localparam int unsigned D = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_p;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [2*W-1:0] rsp_prod;
`ifdef MUL_SCHED_STATS_EN
    logic [1:0]     stat_sel;
    logic [15:0]    stat_cnt;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int n_pop = 0;
    logic [17:0] sb_q [$];

    always #5 clk = ~clk;

    assign mul_p = 16'(mul_a) * 16'(mul_b);

    mul_sched #(
        .WIDTH       (W),
        .NUM_REQ     (N),
        .PIPE_STAGES (P),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod)
`ifdef MUL_SCHED_STATS_EN
        ,
        .stat_sel  (stat_sel),
        .stat_cnt  (stat_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        sb_q.delete();
        nclk(2);
        rst_n = 1'b1;
        nclk(1);
    endtask

    // Requester 0 streams; its multiplicand steps by one after each acceptance.
    task automatic stream0(input int cycles, output int n_acc);
        logic acc;
        n_acc = 0;
        for (int c = 0; c < cycles; c++) begin
            acc = req_ready[0];
            if (acc) n_acc++;
            nclk(1);
            if (acc) req_a[7:0] = req_a[7:0] + 8'd1;
            #1;
        end
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || rsp_valid) && k < 50) begin
            nclk(1);
            k++;
        end
        chk(tag, 32'(sb_q.size()), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    // Scoreboard: record acceptances, check every popped result in order.
    initial begin : monitor
        logic [N-1:0] acc;
        logic [17:0]  e;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                acc = req_valid & req_ready;
                chk("grant_onehot", 32'($onehot0(acc)), 32'd1);
                if (rsp_valid && rsp_ready) begin
                    n_pop++;
                    chk("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("sb_rsp_id", 32'(rsp_id), 32'(e[17:16]));
                        chk("sb_rsp_prod", 32'(rsp_prod), 32'(e[15:0]));
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (acc[i]) sb_q.push_back({2'(i), 16'(req_a[i*W +: W]) * 16'(req_b[i*W +: W])});
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          n;
        int          base;
        int          tot;
        logic [3:0]  eg;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
`ifdef MUL_SCHED_STATS_EN
        stat_sel  = '0;
`endif
        rst_n = 1'b0;
        nclk(2);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_prod", 32'(rsp_prod), 32'd0);
        req_valid = '1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        nclk(1);
        req_valid = '0;
        rst_n     = 1'b1;
        for (int c = 0; c < 20; c++) begin
            nclk(1);
            chk("idle", 32'({rsp_valid, req_ready}), 32'd0);
        end

        // Single request with latency check.
        set_req(2, 8'hFF, 8'hFF);
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        nclk(1);
        req_valid = '0;
        chk("single_mul_a", 32'(mul_a), 32'hFF);
        chk("single_mul_b", 32'(mul_b), 32'hFF);
        chk("single_lat_k", 32'(rsp_valid), 32'd0);
        nclk(1);
        chk("single_lat_k1", 32'(rsp_valid), 32'd0);
        nclk(1);
        chk("single_lat_k2", 32'(rsp_valid), 32'd1);
        chk("single_id", 32'(rsp_id), 32'd2);
        chk("single_prod", 32'(rsp_prod), 32'hFE01);
        nclk(1);
        chk("single_popped", 32'(rsp_valid), 32'd0);
        chk("idle_hold_mul_a", 32'(mul_a), 32'hFF);

        // Fairness with all requesters valid.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 8'(33 * (i + 1)), 8'(13 + i));
        rsp_ready = 1'b1;
        req_valid = '1;
        base = n_pop;
        #1;
        for (int c = 0; c < 8; c++) begin
            eg = 4'b0001 << (c % 4);
            chk("fair_grant", 32'(req_ready), 32'(eg));
            if (c >= 3) chk("fair_stream", 32'(rsp_valid), 32'd1);
            nclk(1);
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            chk("fair_tail", 32'(rsp_valid), 32'd1);
            nclk(1);
        end
        wait_drain("fair_drain");
        chk("fair_pops", 32'(n_pop - base), 32'd8);

        // Backpressure fills exactly FIFO_DEPTH credits.
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 8'h30, 8'h05);
        req_valid = 4'b0001;
        base = n_pop;
        #1;
        stream0(10, n);
        tot = n;
        chk("bp_accepts", 32'(n), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_hold_id", 32'(rsp_id), 32'd0);
        chk("bp_hold_prod", 32'(rsp_prod), 32'h00F0);
        nclk(3);
        chk("bp_hold_prod2", 32'(rsp_prod), 32'h00F0);
        chk("bp_ready_low2", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        #1;
        stream0(8, n);
        tot = tot + n;
        req_valid = '0;
        wait_drain("bp_drain");
        chk("bp_no_loss", 32'(n_pop - base), 32'(tot));

        // Reset with three results pending.
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 8'h40, 8'h02);
        req_valid = 4'b0001;
        #1;
        stream0(3, n);
        chk("mid_accepts", 32'(n), 32'd3);
        rst_n     = 1'b0;
        req_valid = '0;
        sb_q.delete();
        nclk(2);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            nclk(1);
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
`ifdef MUL_SCHED_STATS_EN
        for (int i = 0; i < N; i++) begin
            stat_sel = 2'(i);
            #1;
            chk("stat_cleared", 32'(stat_cnt), 32'd0);
        end
`endif
        set_req(1, 8'h12, 8'h34);
        req_valid = 4'b0010;
        #1;
        chk("mid_new_ready", 32'(req_ready), 32'h2);
        nclk(1);
        req_valid = '0;
        nclk(2);
        chk("mid_new_valid", 32'(rsp_valid), 32'd1);
        chk("mid_new_id", 32'(rsp_id), 32'd1);
        chk("mid_new_prod", 32'(rsp_prod), 32'h03A8);
`ifdef MUL_SCHED_STATS_EN
        stat_sel = 2'd1;
        #1;
        chk("stat_one", 32'(stat_cnt), 32'd1);
`endif
        wait_drain("mid_drain");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
